alu_issue: RTL and testbench

//  Operand/command driver for the 32-bit ALU: accepts a MIPS instruction plus register values.

---
 rtl/alu_issue_pkg.sv | 54 +++++
 rtl/alu_issue_dec.sv | 73 +++++++
 rtl/alu_issue.sv | 137 +++++++++++++
 tb/tb_alu_issue.sv | 299 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_issue_pkg.sv
// ============================================================================
// alu_issue_pkg : ALU op / MIPS opcode+funct constants, issue FSM states,
//                 issue entry type. Revision 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

package alu_issue_pkg;

  localparam int C_DW  = 32;
  localparam int C_OPW = 4;

  localparam logic [C_OPW-1:0] ALUOP_ADD = 4'd0;
  localparam logic [C_OPW-1:0] ALUOP_SUB = 4'd1;
  localparam logic [C_OPW-1:0] ALUOP_AND = 4'd2;
  localparam logic [C_OPW-1:0] ALUOP_OR  = 4'd3;
  localparam logic [C_OPW-1:0] ALUOP_NOR = 4'd4;
  localparam logic [C_OPW-1:0] ALUOP_SLT = 4'd5;

  localparam logic [5:0] OPC_RTYPE = 6'h00;
  localparam logic [5:0] OPC_ADDI  = 6'h08;
  localparam logic [5:0] OPC_ADDIU = 6'h09;
  localparam logic [5:0] OPC_SLTI  = 6'h0A;
  localparam logic [5:0] OPC_ANDI  = 6'h0C;
  localparam logic [5:0] OPC_ORI   = 6'h0D;

  localparam logic [5:0] FUNCT_ADD  = 6'h20;
  localparam logic [5:0] FUNCT_ADDU = 6'h21;
  localparam logic [5:0] FUNCT_SUB  = 6'h22;
  localparam logic [5:0] FUNCT_SUBU = 6'h23;
  localparam logic [5:0] FUNCT_AND  = 6'h24;
  localparam logic [5:0] FUNCT_OR   = 6'h25;
  localparam logic [5:0] FUNCT_NOR  = 6'h27;
  localparam logic [5:0] FUNCT_SLT  = 6'h2A;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } state_e;

  typedef struct packed {
    logic [C_OPW-1:0] op;
    logic [C_DW-1:0]  p1;
    logic [C_DW-1:0]  p2;
    logic [4:0]       dst;
    logic             illegal;
  } issue_t;

  localparam issue_t ISSUE_RESET = '{op: ALUOP_ADD, p1: '0, p2: '0, dst: '0, illegal: 1'b0};

endpackage

`default_nettype wire

// File: rtl/alu_issue_dec.sv
// ============================================================================
// alu_issue_dec : combinational MIPS decode to ALU op, operands, destination.
// Revision 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module alu_issue_dec
  import alu_issue_pkg::*;
(
  input  logic [31:0] instr_i,
  input  logic [31:0] rs_val_i,
  input  logic [31:0] rt_val_i,
  output logic [3:0]  op_o,
  output logic [31:0] p1_o,
  output logic [31:0] p2_o,
  output logic [4:0]  dst_o,
  output logic        illegal_o
);

  logic [5:0]  w_opcode;
  logic [5:0]  w_funct;
  logic [31:0] w_imm_sx;
  logic [31:0] w_imm_zx;
  logic        w_legal;
  logic        unused_rs_field;

  assign w_opcode = instr_i[31:26];
  assign w_funct  = instr_i[5:0];
  assign w_imm_sx = {{16{instr_i[15]}}, instr_i[15:0]};
  assign w_imm_zx = {16'h0000, instr_i[15:0]};
  // Operand values arrive already read; the rs register index is not needed here.
  assign unused_rs_field = ^instr_i[25:21];

  always_comb begin
    op_o    = ALUOP_ADD;
    p1_o    = rs_val_i;
    p2_o    = rt_val_i;
    dst_o   = instr_i[15:11];
    w_legal = 1'b1;
    if (w_opcode == OPC_RTYPE) begin
      case (w_funct)
        FUNCT_ADD, FUNCT_ADDU: op_o = ALUOP_ADD;
        FUNCT_SUB, FUNCT_SUBU: op_o = ALUOP_SUB;
        FUNCT_AND:             op_o = ALUOP_AND;
        FUNCT_OR:              op_o = ALUOP_OR;
        FUNCT_NOR:             op_o = ALUOP_NOR;
        FUNCT_SLT:             op_o = ALUOP_SLT;
        default:               w_legal = 1'b0;
      endcase
    end else begin
      dst_o = instr_i[20:16];
      case (w_opcode)
        OPC_ADDI, OPC_ADDIU: begin op_o = ALUOP_ADD; p2_o = w_imm_sx; end
        OPC_SLTI:            begin op_o = ALUOP_SLT; p2_o = w_imm_sx; end
        OPC_ANDI:            begin op_o = ALUOP_AND; p2_o = w_imm_zx; end
        OPC_ORI:             begin op_o = ALUOP_OR;  p2_o = w_imm_zx; end
        default:             w_legal = 1'b0;
      endcase
    end
    // Undecodable words still issue, but as an inert ADD 0,0 -> r0.
    if (!w_legal) begin
      op_o  = ALUOP_ADD;
      p1_o  = '0;
      p2_o  = '0;
      dst_o = '0;
    end
    illegal_o = !w_legal;
  end

endmodule

`default_nettype wire

// File: rtl/alu_issue.sv
// ============================================================================
// alu_issue : decode + 2-entry valid/ready skid register feeding the ALU.
// Optional macro ALU_ISSUE_STATS_EN adds saturating issued/illegal counters.
// Revision 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module alu_issue
  import alu_issue_pkg::*;
#(
  parameter int DW  = 32,
  parameter int OPW = 4
) (
  input  logic           clk_i,
  input  logic           rst_n_i,
  input  logic           in_valid_i,
  output logic           in_ready_o,
  input  logic [31:0]    instr_i,
  input  logic [DW-1:0]  rs_val_i,
  input  logic [DW-1:0]  rt_val_i,
  output logic           out_valid_o,
  input  logic           out_ready_i,
  output logic [DW-1:0]  param_1_o,
  output logic [DW-1:0]  param_2_o,
  output logic [OPW-1:0] alu_op_o,
  output logic [4:0]     dst_o,
  output logic           illegal_o
`ifdef ALU_ISSUE_STATS_EN
  ,
  output logic [31:0]    issued_cnt_o,
  output logic [31:0]    illegal_cnt_o
`endif
);

  state_e state_q, state_d;
  issue_t main_q, main_d;
  issue_t skid_q, skid_d;
  issue_t dec_w;
  logic   in_fire_w;
  logic   out_fire_w;

  logic [3:0]  dec_op_w;
  logic [31:0] dec_p1_w;
  logic [31:0] dec_p2_w;
  logic [4:0]  dec_dst_w;
  logic        dec_ill_w;

  alu_issue_dec u_dec (
    .instr_i   (instr_i),
    .rs_val_i  (rs_val_i),
    .rt_val_i  (rt_val_i),
    .op_o      (dec_op_w),
    .p1_o      (dec_p1_w),
    .p2_o      (dec_p2_w),
    .dst_o     (dec_dst_w),
    .illegal_o (dec_ill_w)
  );

  assign dec_w = '{op: dec_op_w, p1: dec_p1_w, p2: dec_p2_w, dst: dec_dst_w, illegal: dec_ill_w};

  // Gated by rst_n_i so upstream sees no room for the whole reset window.
  assign in_ready_o  = rst_n_i & (state_q != TWO);
  assign out_valid_o = (state_q != EMPTY);
  assign in_fire_w   = in_valid_i & in_ready_o;
  assign out_fire_w  = out_valid_o & out_ready_i;

  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    case (state_q)
      EMPTY: begin
        if (in_fire_w) begin
          state_d = ONE;
          main_d  = dec_w;
        end
      end
      ONE: begin
        if (in_fire_w && out_fire_w) begin
          main_d = dec_w;
        end else if (in_fire_w) begin
          state_d = TWO;
          skid_d  = dec_w;
        end else if (out_fire_w) begin
          state_d = EMPTY;
        end
      end
      TWO: begin
        if (out_fire_w) begin
          state_d = ONE;
          main_d  = skid_q;
        end
      end
      default: state_d = EMPTY;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q <= EMPTY;
      main_q  <= ISSUE_RESET;
      skid_q  <= ISSUE_RESET;
    end else begin
      state_q <= state_d;
      main_q  <= main_d;
      skid_q  <= skid_d;
    end
  end

  assign param_1_o = main_q.p1;
  assign param_2_o = main_q.p2;
  assign alu_op_o  = main_q.op;
  assign dst_o     = main_q.dst;
  assign illegal_o = main_q.illegal;

`ifdef ALU_ISSUE_STATS_EN
  logic [31:0] issued_cnt_q;
  logic [31:0] illegal_cnt_q;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      issued_cnt_q  <= '0;
      illegal_cnt_q <= '0;
    end else if (out_fire_w) begin
      if (issued_cnt_q != 32'hFFFF_FFFF) issued_cnt_q <= issued_cnt_q + 32'd1;
      if (main_q.illegal && (illegal_cnt_q != 32'hFFFF_FFFF)) illegal_cnt_q <= illegal_cnt_q + 32'd1;
    end
  end

  assign issued_cnt_o  = issued_cnt_q;
  assign illegal_cnt_o = illegal_cnt_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_alu_issue.sv
// ============================================================================
// tb_alu_issue : directed + random bench for alu_issue with a queue-based
// reference model. Revision 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_alu_issue;
  import alu_issue_pkg::*;

  typedef struct {
    logic [3:0]  op;
    logic [31:0] p1;
    logic [31:0] p2;
    logic [4:0]  dst;
    logic        ill;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] instr;
  logic [31:0] rs_val;
  logic [31:0] rt_val;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] param_1;
  logic [31:0] param_2;
  logic [3:0]  alu_op;
  logic [4:0]  dst;
  logic        illegal;
`ifdef ALU_ISSUE_STATS_EN
  logic [31:0] issued_cnt;
  logic [31:0] illegal_cnt;
`endif

  int   errors = 0;
  int   checks = 0;
  exp_t q[$];
  logic [31:0] ex_issued  = 0;
  logic [31:0] ex_illegal = 0;

  always #5 clk = ~clk;

  alu_issue #(.DW(32), .OPW(4)) dut (
    .clk_i         (clk),
    .rst_n_i       (rst_n),
    .in_valid_i    (in_valid),
    .in_ready_o    (in_ready),
    .instr_i       (instr),
    .rs_val_i      (rs_val),
    .rt_val_i      (rt_val),
    .out_valid_o   (out_valid),
    .out_ready_i   (out_ready),
    .param_1_o     (param_1),
    .param_2_o     (param_2),
    .alu_op_o      (alu_op),
    .dst_o         (dst),
    .illegal_o     (illegal)
`ifdef ALU_ISSUE_STATS_EN
    ,
    .issued_cnt_o  (issued_cnt),
    .illegal_cnt_o (illegal_cnt)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference semantics: instruction word + operand values -> what the ALU should see.
  function automatic exp_t ref_decode(input logic [31:0] ins, input logic [31:0] rs, input logic [31:0] rt);
    exp_t e;
    logic [5:0]  opc;
    logic [5:0]  fn;
    logic [31:0] sx;
    logic [31:0] zx;
    logic        ok;
    opc = ins[31:26];
    fn  = ins[5:0];
    sx  = 32'($signed(ins[15:0]));
    zx  = 32'(ins[15:0]);
    ok  = 1'b1;
    e   = '{op: ALUOP_ADD, p1: rs, p2: rt, dst: ins[15:11], ill: 1'b0};
    if (opc == 6'h00) begin
      if (fn == 6'h20 || fn == 6'h21)      e.op = ALUOP_ADD;
      else if (fn == 6'h22 || fn == 6'h23) e.op = ALUOP_SUB;
      else if (fn == 6'h24)                e.op = ALUOP_AND;
      else if (fn == 6'h25)                e.op = ALUOP_OR;
      else if (fn == 6'h27)                e.op = ALUOP_NOR;
      else if (fn == 6'h2A)                e.op = ALUOP_SLT;
      else                                 ok = 1'b0;
    end else begin
      e.dst = ins[20:16];
      if (opc == 6'h08 || opc == 6'h09) begin e.op = ALUOP_ADD; e.p2 = sx; end
      else if (opc == 6'h0A)            begin e.op = ALUOP_SLT; e.p2 = sx; end
      else if (opc == 6'h0C)            begin e.op = ALUOP_AND; e.p2 = zx; end
      else if (opc == 6'h0D)            begin e.op = ALUOP_OR;  e.p2 = zx; end
      else                              ok = 1'b0;
    end
    if (!ok) e = '{op: ALUOP_ADD, p1: 32'h0, p2: 32'h0, dst: 5'h0, ill: 1'b1};
    return e;
  endfunction

  function automatic logic [31:0] rtype(input logic [5:0] fn, input logic [4:0] rd);
    return {6'h00, 5'd3, 5'd4, rd, 5'd0, fn};
  endfunction

  function automatic logic [31:0] itype(input logic [5:0] opc, input logic [4:0] rt, input logic [15:0] imm);
    return {opc, 5'd3, rt, imm};
  endfunction

  function automatic logic [31:0] rand_instr();
    int          k;
    logic [31:0] w;
    k = $urandom_range(0, 15);
    w = $urandom();
    if (k < 8) begin
      w[31:26] = 6'h00;
      case (k)
        0: w[5:0] = 6'h20;
        1: w[5:0] = 6'h21;
        2: w[5:0] = 6'h22;
        3: w[5:0] = 6'h23;
        4: w[5:0] = 6'h24;
        5: w[5:0] = 6'h25;
        6: w[5:0] = 6'h27;
        default: w[5:0] = 6'h2A;
      endcase
    end else begin
      case (k)
        8:  w[31:26] = 6'h08;
        9:  w[31:26] = 6'h09;
        10: w[31:26] = 6'h0A;
        11: w[31:26] = 6'h0C;
        12: w[31:26] = 6'h0D;
        13: w[31:26] = 6'h3F;
        14: begin w[31:26] = 6'h00; w[5:0] = 6'h26; end
        default: w[31:26] = 6'h02;
      endcase
    end
    return w;
  endfunction

  task automatic check_state();
    chk("in_ready", {31'b0, in_ready}, {31'b0, q.size() < 2});
    chk("out_valid", {31'b0, out_valid}, {31'b0, q.size() > 0});
    if (q.size() > 0) begin
      chk("alu_op", {28'b0, alu_op}, {28'b0, q[0].op});
      chk("param_1", param_1, q[0].p1);
      chk("param_2", param_2, q[0].p2);
      chk("dst", {27'b0, dst}, {27'b0, q[0].dst});
      chk("illegal", {31'b0, illegal}, {31'b0, q[0].ill});
    end
`ifdef ALU_ISSUE_STATS_EN
    chk("issued_cnt", issued_cnt, ex_issued);
    chk("illegal_cnt", illegal_cnt, ex_illegal);
`endif
  endtask

  // Called at a falling edge; returns at the next falling edge.
  task automatic cycle(input logic v, input logic [31:0] ins, input logic [31:0] rs,
                       input logic [31:0] rt, input logic ordy);
    logic infire;
    logic outfire;
    in_valid  = v;
    instr     = ins;
    rs_val    = rs;
    rt_val    = rt;
    out_ready = ordy;
    #1;
    check_state();
    infire  = v && (q.size() < 2);
    outfire = ordy && (q.size() > 0);
    @(posedge clk);
    if (outfire) begin
      if (ex_issued != 32'hFFFF_FFFF) ex_issued = ex_issued + 1;
      if (q[0].ill && ex_illegal != 32'hFFFF_FFFF) ex_illegal = ex_illegal + 1;
      void'(q.pop_front());
    end
    if (infire) q.push_back(ref_decode(ins, rs, rt));
    @(negedge clk);
  endtask

  task automatic idle(input logic ordy);
    cycle(1'b0, 32'h0, 32'h0, 32'h0, ordy);
  endtask

  initial begin
    logic [5:0] fns [6];
    logic [31:0] a_ins;
    fns[0] = 6'h20; fns[1] = 6'h22; fns[2] = 6'h24;
    fns[3] = 6'h25; fns[4] = 6'h27; fns[5] = 6'h2A;

    rst_n = 1'b0; in_valid = 1'b0; instr = '0; rs_val = '0; rt_val = '0; out_ready = 1'b0;
    #3;
    chk("rst_in_ready", {31'b0, in_ready}, 32'h0);
    chk("rst_out_valid", {31'b0, out_valid}, 32'h0);
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("rel_in_ready", {31'b0, in_ready}, 32'h1);
    chk("rel_out_valid", {31'b0, out_valid}, 32'h0);
    chk("rel_param_1", param_1, 32'h0);
    chk("rel_param_2", param_2, 32'h0);
    chk("rel_alu_op", {28'b0, alu_op}, {28'b0, ALUOP_ADD});
    chk("rel_dst", {27'b0, dst}, 32'h0);
    chk("rel_illegal", {31'b0, illegal}, 32'h0);
    @(negedge clk);

    // R-type ops, each preceded by ADD with both operands 17
    foreach (fns[i]) begin
      cycle(1'b1, rtype(6'h20, 5'd9), 32'd17, 32'd17, 1'b1);
      cycle(1'b1, rtype(fns[i], 5'(10 + i)), 32'd17, 32'd17, 1'b1);
      idle(1'b1);
    end
    cycle(1'b1, rtype(6'h20, 5'd9), 32'd17, 32'd17, 1'b1);
    chk("add_p1", param_1, 32'd17);
    chk("add_p2", param_2, 32'd17);
    chk("add_dst", {27'b0, dst}, 32'd9);
    cycle(1'b1, itype(6'h08, 5'd7, 16'hFFFF), 32'd17, 32'd17, 1'b1);
    chk("addi_p2", param_2, 32'hFFFF_FFFF);
    cycle(1'b1, itype(6'h0D, 5'd12, 16'hFFFF), 32'd17, 32'd17, 1'b1);
    chk("ori_p2", param_2, 32'h0000_FFFF);
    chk("ori_dst", {27'b0, dst}, 32'd12);
    chk("ori_op", {28'b0, alu_op}, {28'b0, ALUOP_OR});
    idle(1'b1);

    // Backpressure: A,B fill both entries, C must wait, then all drain in order
    cycle(1'b1, rtype(6'h22, 5'd1), 32'hA, 32'h1, 1'b0);
    cycle(1'b1, rtype(6'h24, 5'd2), 32'hB, 32'h2, 1'b0);
    cycle(1'b1, rtype(6'h25, 5'd3), 32'hC, 32'h3, 1'b0);
    chk("bp_full_ready", {31'b0, in_ready}, 32'h0);
    chk("bp_head_a", param_1, 32'hA);
    cycle(1'b1, rtype(6'h25, 5'd3), 32'hC, 32'h3, 1'b1);
    cycle(1'b1, rtype(6'h25, 5'd3), 32'hC, 32'h3, 1'b1);
    idle(1'b1);
    idle(1'b1);

    // Illegal opcode
    cycle(1'b1, 32'hFC00_FFFF, 32'h1234, 32'h5678, 1'b1);
    chk("ill_flag", {31'b0, illegal}, 32'h1);
    chk("ill_op", {28'b0, alu_op}, {28'b0, ALUOP_ADD});
    chk("ill_p1", param_1, 32'h0);
    chk("ill_p2", param_2, 32'h0);
    idle(1'b1);
    idle(1'b1);

    // Streaming at full rate
    for (int n = 0; n < 100; n++) cycle(1'b1, rand_instr(), $urandom(), $urandom(), 1'b1);
    chk("stream_ready", {31'b0, in_ready}, 32'h1);
    chk("stream_valid", {31'b0, out_valid}, 32'h1);

    // Random valid/ready mix
    for (int n = 0; n < 300; n++)
      cycle(1'($urandom_range(0, 1)), rand_instr(), $urandom(), $urandom(),
            1'($urandom_range(0, 3) != 0));

    // Mid-operation reset while both entries are occupied
    idle(1'b1); idle(1'b1);
    cycle(1'b1, rtype(6'h20, 5'd5), 32'h55, 32'h66, 1'b0);
    cycle(1'b1, rtype(6'h22, 5'd6), 32'h77, 32'h88, 1'b0);
    a_ins = 32'h0;
    in_valid = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", {31'b0, out_valid}, 32'h0);
    chk("mid_rst_ready", {31'b0, in_ready}, 32'h0);
    q.delete();
    ex_issued = 0;
    ex_illegal = 0;
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("post_rst_param_1", param_1, a_ins);
    @(negedge clk);
    for (int n = 0; n < 4; n++) idle(1'b1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    errors++;
    $display("FAIL timeout: observed=running expected=finished");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $fatal(1, "simulation time limit");
  end

endmodule

`default_nettype wire
